// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the hardwired control sequencer: opcodes, T-state
//   enum, register FunSel codes, ARF select/enable encodings, the control-word
//   struct and its NOP value, plus small field helpers.
package control_sequencer_pkg;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LDI  = 4'h1;
    localparam logic [3:0] OPC_ADD  = 4'h2;
    localparam logic [3:0] OPC_SUB  = 4'h3;
    localparam logic [3:0] OPC_LD   = 4'h4;
    localparam logic [3:0] OPC_ST   = 4'h5;
    localparam logic [3:0] OPC_BEQ  = 4'h6;
    localparam logic [3:0] OPC_BRA  = 4'h7;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    // Register FunSel codes (RF, ARF, IR)
    localparam logic [1:0] FS_DEC   = 2'b00;
    localparam logic [1:0] FS_INC   = 2'b01;
    localparam logic [1:0] FS_LOAD  = 2'b10;
    localparam logic [1:0] FS_CLEAR = 2'b11;

    // ARF output selects
    localparam logic [1:0] ARF_SEL_PC = 2'b00;
    localparam logic [1:0] ARF_SEL_AR = 2'b01;
    localparam logic [1:0] ARF_SEL_SP = 2'b10;

    // ARF register enables
    localparam logic [3:0] ARF_EN_PC = 4'b0100;
    localparam logic [3:0] ARF_EN_AR = 4'b0010;
    localparam logic [3:0] ARF_EN_SP = 4'b0001;

    // Datapath mux sources
    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_IMM = 2'b01;
    localparam logic [1:0] MUXA_MEM = 2'b10;
    localparam logic [1:0] MUXB_IMM = 2'b01;

    // ALU functions
    localparam logic [3:0] ALU_PASSA = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;

    typedef struct packed {
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic [1:0] rf_funsel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_funsel;
        logic [1:0] arf_outasel;
        logic [1:0] arf_outbsel;
        logic [1:0] arf_funsel;
        logic [3:0] arf_rsel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_funsel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] muxasel;
        logic [1:0] muxbsel;
        logic       muxcsel;
    } ctrl_word_t;

    // Idle word: nothing enabled, memory deselected (CS is active-low)
    localparam ctrl_word_t NOP_WORD = '{
        rf_o1sel:    3'b000,
        rf_o2sel:    3'b000,
        rf_funsel:   2'b00,
        rf_rsel:     4'b0000,
        rf_tsel:     4'b0000,
        alu_funsel:  4'b0000,
        arf_outasel: 2'b00,
        arf_outbsel: 2'b00,
        arf_funsel:  2'b00,
        arf_rsel:    4'b0000,
        ir_lh:       1'b0,
        ir_enable:   1'b0,
        ir_funsel:   2'b00,
        mem_wr:      1'b0,
        mem_cs:      1'b1,
        muxasel:     2'b00,
        muxbsel:     2'b00,
        muxcsel:     1'b0
    };

    // General register r (0..3 = R1..R4) as an RF enable: R1 is bit 3
    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

    // General register r as an RF output select: 100..111 = R1..R4
    function automatic logic [2:0] rf_osel(input logic [1:0] r);
        return {1'b1, r};
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// cs_decode
//   Combinational control-word decoder: maps (T-state, latched opcode and
//   register fields, Z flag) to the full datapath control word.
//   Ports:
//     tstate      current T-state
//     idle        force the NOP word (halted or waiting in T0)
//     opcode      latched opcode
//     rd/rs1/rs2  latched register fields
//     z           ALU zero flag, consulted only in T2 of BEQ
//     cw          control word
//     illegal     high during T2 of an undefined opcode
module cs_decode
    import control_sequencer_pkg::*;
#(
    parameter logic [3:0] HALT_OPC = 4'hF
) (
    input  tstate_t    tstate,
    input  logic       idle,
    input  logic [3:0] opcode,
    input  logic [1:0] rd,
    input  logic [1:0] rs1,
    input  logic [1:0] rs2,
    input  logic       z,
    output ctrl_word_t cw,
    output logic       illegal
);

    always_comb begin
        cw      = NOP_WORD;
        illegal = 1'b0;
        if (!idle) begin
            case (tstate)
                T0, T1: begin
                    // Fetch one instruction byte from memory[PC], then PC++
                    cw.arf_outbsel = ARF_SEL_PC;
                    cw.mem_cs      = 1'b0;
                    cw.mem_wr      = 1'b0;
                    cw.ir_enable   = 1'b1;
                    cw.ir_lh       = (tstate == T1);
                    cw.ir_funsel   = FS_LOAD;
                    cw.arf_rsel    = ARF_EN_PC;
                    cw.arf_funsel  = FS_INC;
                end
                T2: begin
                    if (opcode != HALT_OPC) begin
                        case (opcode)
                            OPC_NOP: ;
                            OPC_LDI: begin
                                cw.muxasel   = MUXA_IMM;
                                cw.rf_rsel   = rf_onehot(rd);
                                cw.rf_funsel = FS_LOAD;
                            end
                            OPC_ADD, OPC_SUB: begin
                                cw.rf_o1sel   = rf_osel(rs1);
                                cw.rf_o2sel   = rf_osel(rs2);
                                cw.alu_funsel = (opcode == OPC_ADD) ? ALU_ADD : ALU_SUB;
                                cw.muxasel    = MUXA_ALU;
                                cw.rf_rsel    = rf_onehot(rd);
                                cw.rf_funsel  = FS_LOAD;
                            end
                            OPC_LD, OPC_ST: begin
                                cw.muxbsel    = MUXB_IMM;
                                cw.arf_rsel   = ARF_EN_AR;
                                cw.arf_funsel = FS_LOAD;
                            end
                            OPC_BEQ: begin
                                if (z) begin
                                    cw.muxbsel    = MUXB_IMM;
                                    cw.arf_rsel   = ARF_EN_PC;
                                    cw.arf_funsel = FS_LOAD;
                                end
                            end
                            OPC_BRA: begin
                                cw.muxbsel    = MUXB_IMM;
                                cw.arf_rsel   = ARF_EN_PC;
                                cw.arf_funsel = FS_LOAD;
                            end
                            default: illegal = 1'b1;
                        endcase
                    end
                end
                T3: begin
                    case (opcode)
                        OPC_LD: begin
                            cw.arf_outbsel = ARF_SEL_AR;
                            cw.mem_cs      = 1'b0;
                            cw.mem_wr      = 1'b0;
                            cw.muxasel     = MUXA_MEM;
                            cw.rf_rsel     = rf_onehot(rd);
                            cw.rf_funsel   = FS_LOAD;
                        end
                        OPC_ST: begin
                            cw.rf_o1sel    = rf_osel(rd);
                            cw.alu_funsel  = ALU_PASSA;
                            cw.arf_outbsel = ARF_SEL_AR;
                            cw.mem_cs      = 1'b0;
                            cw.mem_wr      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the ALU_System datapath. Fetches a 16-bit
//   instruction as two bytes (T0, T1), latches its fields at the end of T1,
//   and sequences execute states T2..T3 before returning to T0.
//   Ports:
//     Clock, Reset (sync, active-low)
//     IROut       IR contents: [15:12] opcode, [11:10] Rd, [9:8] Rs1,
//                 [7:6] Rs2, [7:0] imm/addr
//     ALUOutFlag  {Z,C,N,O}
//     Step        single-step request (only with CTRL_STEP_EN)
//     RF_*/ALU_*/ARF_*/IR_*/Mem_*/Mux* datapath control word
//     TState      current T-state, Halted, Illegal (T2 pulse)
//   Configuration: define CTRL_STEP_EN to add the Step port; the sequencer then
//   idles in T0 with the NOP word until Step is sampled high.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter logic [3:0] HALT_OPC = 4'hF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
`ifdef CTRL_STEP_EN
    input  logic        Step,
`endif
    output logic [2:0]  RF_O1Sel,
    output logic [2:0]  RF_O2Sel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  TState,
    output logic        Halted,
    output logic        Illegal
);

    tstate_t    tstate;
    logic       halted;
    logic       fetch_en;   // T0 actually fetches; clear = idle in T0 with NOP word
    logic [3:0] op_q;
    logic [1:0] rd_q;
    logic [1:0] rs1_q;
    logic [1:0] rs2_q;
    logic       run_req;
    logic       idle;
    ctrl_word_t cw;
    logic       unused_inputs;

`ifdef CTRL_STEP_EN
    assign run_req = Step;
`else
    assign run_req = 1'b1;
`endif

    // The low immediate bits and C/N/O are datapath-only
    assign unused_inputs = ^{IROut[5:0], ALUOutFlag[2:0]};

    // After reset and between stepped instructions the sequencer sits in T0
    // with fetch_en clear, which keeps the NOP word on the outputs for one
    // (or more) cycles before the real T0 fetch.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            tstate   <= T0;
            halted   <= 1'b0;
            fetch_en <= 1'b0;
            op_q     <= OPC_NOP;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else if (!halted) begin
            case (tstate)
                T0: begin
                    if (fetch_en) tstate   <= T1;
                    else          fetch_en <= run_req;
                end
                T1: begin
                    tstate <= T2;
                    op_q   <= IROut[15:12];
                    rd_q   <= IROut[11:10];
                    rs1_q  <= IROut[9:8];
                    rs2_q  <= IROut[7:6];
                end
                T2: begin
                    if (op_q == HALT_OPC) begin
                        tstate   <= T0;
                        halted   <= 1'b1;
                        fetch_en <= 1'b0;
                    end else if (op_q == OPC_LD || op_q == OPC_ST) begin
                        tstate <= T3;
                    end else begin
                        tstate   <= T0;
                        fetch_en <= run_req;
                    end
                end
                default: begin
                    tstate   <= T0;
                    fetch_en <= run_req;
                end
            endcase
        end
    end

    assign idle = halted || (tstate == T0 && !fetch_en);

    cs_decode #(.HALT_OPC(HALT_OPC)) u_decode (
        .tstate  (tstate),
        .idle    (idle),
        .opcode  (op_q),
        .rd      (rd_q),
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .z       (ALUOutFlag[3]),
        .cw      (cw),
        .illegal (Illegal)
    );

    assign RF_O1Sel    = cw.rf_o1sel;
    assign RF_O2Sel    = cw.rf_o2sel;
    assign RF_FunSel   = cw.rf_funsel;
    assign RF_RSel     = cw.rf_rsel;
    assign RF_TSel     = cw.rf_tsel;
    assign ALU_FunSel  = cw.alu_funsel;
    assign ARF_OutASel = cw.arf_outasel;
    assign ARF_OutBSel = cw.arf_outbsel;
    assign ARF_FunSel  = cw.arf_funsel;
    assign ARF_RSel    = cw.arf_rsel;
    assign IR_LH       = cw.ir_lh;
    assign IR_Enable   = cw.ir_enable;
    assign IR_Funsel   = cw.ir_funsel;
    assign Mem_WR      = cw.mem_wr;
    assign Mem_CS      = cw.mem_cs;
    assign MuxASel     = cw.muxasel;
    assign MuxBSel     = cw.muxbsel;
    assign MuxCSel     = cw.muxcsel;
    assign TState      = tstate;
    assign Halted      = halted;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic        Step;
    logic [2:0]  RF_O1Sel, RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [2:0]  TState;
    logic        Halted, Illegal;

    int checks = 0;
    int passed = 0;

    // Only Mem_CS (bit 5 of the packed word) is high in the idle word
    localparam logic [40:0] NOP_EXP = 41'h20;

    logic [40:0] dut_word;
    assign dut_word = {RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                       ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel, IR_LH, IR_Enable,
                       IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

    control_sequencer #(.HALT_OPC(4'hF)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (IROut),
        .ALUOutFlag  (ALUOutFlag),
`ifdef CTRL_STEP_EN
        .Step        (Step),
`endif
        .RF_O1Sel    (RF_O1Sel),
        .RF_O2Sel    (RF_O2Sel),
        .RF_FunSel   (RF_FunSel),
        .RF_RSel     (RF_RSel),
        .RF_TSel     (RF_TSel),
        .ALU_FunSel  (ALU_FunSel),
        .ARF_OutASel (ARF_OutASel),
        .ARF_OutBSel (ARF_OutBSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RSel    (ARF_RSel),
        .IR_LH       (IR_LH),
        .IR_Enable   (IR_Enable),
        .IR_Funsel   (IR_Funsel),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .TState      (TState),
        .Halted      (Halted),
        .Illegal     (Illegal)
    );

    always #5 Clock = ~Clock;

    // Reference: control word of cycle k (0-based from T0) of one instruction
    function automatic logic [40:0] model(input logic [3:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2,
                                          input logic z, input int unsigned k);
        logic [2:0] o1, o2;
        logic [1:0] rff, aa, ab, af, irf, ma, mb;
        logic [3:0] rrs, rts, alu, ars;
        logic       lh, ie, wr, cs, mc;
        o1 = 0; o2 = 0; rff = 0; aa = 0; ab = 0; af = 0; irf = 0; ma = 0; mb = 0;
        rrs = 0; rts = 0; alu = 0; ars = 0; lh = 0; ie = 0; wr = 0; cs = 1; mc = 0;
        if (k < 2) begin
            ab = 2'b00; cs = 0; ie = 1; lh = (k == 1); irf = 2'b10;
            ars = 4'b0100; af = 2'b01;
        end else if (k == 2) begin
            case (op)
                4'h1: begin ma = 2'b01; rrs = 4'b1000 >> rd; rff = 2'b10; end
                4'h2, 4'h3: begin
                    o1 = 3'd4 + 3'(rs1); o2 = 3'd4 + 3'(rs2);
                    alu = (op == 4'h2) ? 4'b0100 : 4'b0110;
                    ma = 2'b00; rrs = 4'b1000 >> rd; rff = 2'b10;
                end
                4'h4, 4'h5: begin mb = 2'b01; ars = 4'b0010; af = 2'b10; end
                4'h6: if (z) begin mb = 2'b01; ars = 4'b0100; af = 2'b10; end
                4'h7: begin mb = 2'b01; ars = 4'b0100; af = 2'b10; end
                default: ;
            endcase
        end else if (k == 3) begin
            if (op == 4'h4) begin
                ab = 2'b01; cs = 0; ma = 2'b10; rrs = 4'b1000 >> rd; rff = 2'b10;
            end else if (op == 4'h5) begin
                o1 = 3'd4 + 3'(rd); alu = 4'b0000; ab = 2'b01; cs = 0; wr = 1;
            end
        end
        return {o1, o2, rff, rrs, rts, alu, aa, ab, af, ars, lh, ie, irf, wr, cs, ma, mb, mc};
    endfunction

    // Drives one instruction from its T0 and checks every cycle until it ends.
    // Z is held at the wrong value until T2 so only the T2 sample matters, and
    // IROut is scrambled after the field latch to prove T3 uses latched fields.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [7:0] imm, input logic z, input string tag);
        int unsigned len;
        logic [1:0]  rs2;
        logic        ill_exp;
        rs2 = imm[7:6];
        len = (op == 4'h4 || op == 4'h5) ? 4 : 3;
        IROut = {op, rd, rs1, imm};
        ALUOutFlag = {~z, 3'($urandom_range(0, 7))};
        for (int unsigned k = 0; k < len; k++) begin
            @(negedge Clock);
            checks++;
            if (TState !== 3'(k)) $display("FAIL %s tstate k=%0d: got %0d exp %0d", tag, k, TState, k);
            else passed++;
            checks++;
            if (dut_word !== model(op, rd, rs1, rs2, z, k))
                $display("FAIL %s word k=%0d: got %h exp %h", tag, k, dut_word, model(op, rd, rs1, rs2, z, k));
            else passed++;
            ill_exp = (k == 2) && (op >= 4'h8) && (op != 4'hF);
            checks++;
            if ({Illegal, Halted} !== {ill_exp, 1'b0})
                $display("FAIL %s ill/halt k=%0d: got %b%b exp %b0", tag, k, Illegal, Halted, ill_exp);
            else passed++;
            if (k == 1) ALUOutFlag = {z, 3'($urandom_range(0, 7))};
            if (k == 2) IROut = 16'($urandom);
        end
    endtask

    task automatic check_idle(input string tag, input logic halt_exp);
        checks++;
        if ({TState, Halted, Illegal} !== {3'd0, halt_exp, 1'b0})
            $display("FAIL %s state: got t=%0d h=%b i=%b exp t=0 h=%b i=0", tag, TState, Halted, Illegal, halt_exp);
        else passed++;
        checks++;
        if (dut_word !== NOP_EXP) $display("FAIL %s word: got %h exp %h", tag, dut_word, NOP_EXP);
        else passed++;
    endtask

    task automatic test_reset();
        Reset = 1'b0; IROut = '0; ALUOutFlag = '0; Step = 1'b1;
        repeat (2) begin
            @(negedge Clock);
            check_idle("reset", 1'b0);
        end
        Reset = 1'b1;
    endtask

    task automatic test_directed();
        run_instr(4'h1, 2'b01, 2'b00, 8'h2A, 1'b0, "ldi_r2");
        run_instr(4'h2, 2'b00, 2'b01, 8'h80, 1'b0, "add_r1_r2_r3");
        run_instr(4'h3, 2'b11, 2'b10, 8'h40, 1'b1, "sub");
        run_instr(4'h4, 2'b10, 2'b00, 8'h33, 1'b0, "ld");
        run_instr(4'h5, 2'b11, 2'b00, 8'h80, 1'b0, "st_r4");
        run_instr(4'h6, 2'b00, 2'b00, 8'h10, 1'b0, "beq_z0");
        run_instr(4'h6, 2'b00, 2'b00, 8'h10, 1'b1, "beq_z1");
        run_instr(4'h7, 2'b00, 2'b00, 8'h55, 1'b0, "bra");
        run_instr(4'h0, 2'b00, 2'b00, 8'h00, 1'b0, "nop");
        run_instr(4'h9, 2'b01, 2'b10, 8'hC3, 1'b0, "illegal_9");
    endtask

    task automatic test_reset_mid_ld();
        IROut = 16'h4C40;
        ALUOutFlag = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge Clock);
            checks++;
            if (dut_word !== model(4'h4, 2'b11, 2'b00, 2'b01, 1'b0, k))
                $display("FAIL abort_ld word k=%0d: got %h exp %h", k, dut_word,
                         model(4'h4, 2'b11, 2'b00, 2'b01, 1'b0, k));
            else passed++;
        end
        Reset = 1'b0;
        repeat (2) begin
            @(negedge Clock);
            check_idle("abort_ld", 1'b0);
        end
        Reset = 1'b1;
        run_instr(4'h1, 2'b11, 2'b00, 8'h07, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(0, 14)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_halt();
        run_instr(4'hF, 2'b00, 2'b00, 8'h00, 1'b0, "halt");
        for (int i = 0; i < 6; i++) begin
            IROut = 16'($urandom);
            ALUOutFlag = 4'($urandom_range(0, 15));
            @(negedge Clock);
            check_idle("halted", 1'b1);
        end
        Reset = 1'b0;
        @(negedge Clock);
        check_idle("halt_reset", 1'b0);
        Reset = 1'b1;
        run_instr(4'h2, 2'b01, 2'b11, 8'hC0, 1'b0, "after_halt");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_ld();
        test_back_to_back_random();
        test_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
